// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and priority helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ             = 8;
    localparam int IDX_W               = 3;
    localparam int DEF_TIMEOUT_CYCLES  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Offset of the lowest set bit; callers only use it when the vector is nonzero.
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_REQ-1:0] vec);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                pos = IDX_W'(i);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/rr_arbiter8_grant_decoder.sv
// 3-to-8 one-hot decode of the registered grant index, gated by grant_valid.
module grant_decoder
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   grant_idx,
    input  logic               grant_valid,
    output logic [NUM_REQ-1:0] grant
);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; a grant is held until released, then the pointer rotates.
// Optional hold-time limit with forced revoke is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic               timeout
);

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("rr_arbiter8: TIMEOUT_CYCLES must be within 1..255");
        end
    endgenerate

    state_t             state_reg;
    logic [IDX_W-1:0]   grant_idx_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] rotated_req;
    logic [IDX_W-1:0]   pick_idx;
    logic               normal_release;
    logic               force_release;

    // Rotate requests so that bit 0 of rotated_req is the requester at ptr_reg.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W-1:0] src_idx;
            assign src_idx         = ptr_reg + IDX_W'(gi);
            assign rotated_req[gi] = req[src_idx];
        end
    endgenerate

    assign pick_idx       = ptr_reg + first_set(rotated_req);
    assign normal_release = done || !req[grant_idx_reg];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] hold_cnt_reg;
    logic       timeout_reg;

    assign force_release = (hold_cnt_reg == HOLD_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            if (state_reg == IDLE) begin
                hold_cnt_reg <= '0;
            end else if (!normal_release && force_release) begin
                timeout_reg  <= 1'b1;
                hold_cnt_reg <= '0;
            end else begin
                hold_cnt_reg <= hold_cnt_reg + 8'd1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_idx_reg <= '0;
            ptr_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg     <= BUSY;
                        grant_idx_reg <= pick_idx;
                    end
                end
                BUSY: begin
                    // Returning to IDLE here is what enforces the one-cycle gap between grants.
                    if (normal_release || force_release) begin
                        state_reg     <= IDLE;
                        grant_idx_reg <= '0;
                        ptr_reg       <= grant_idx_reg + IDX_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant_valid = (state_reg == BUSY);
    assign grant_idx   = grant_idx_reg;

    grant_decoder u_grant_decoder (
        .grant_idx   (grant_idx_reg),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus queues expected grants, a monitor checks each new grant.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int idx;
        int at;
    } exp_t;

    exp_t sb[$];

    rr_arbiter8 #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant       (grant),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, cyc, act, act, exp, exp);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    // Expect a new grant to idx to become visible dly edges from now.
    task automatic expect_at(input int idx, input int dly);
        exp_t e;
        e.idx = idx;
        e.at  = cyc + dly;
        sb.push_back(e);
    endtask

    // Monitor: detects each new grant and checks it against the head of the scoreboard.
    logic       prev_valid = 1'b0;
    logic [2:0] prev_idx   = 3'd0;

    always @(negedge clk) begin
        logic [7:0] exp_grant;
        exp_t       e;
        exp_grant = grant_valid ? (8'd1 << grant_idx) : 8'd0;
        if (grant !== exp_grant) begin
            chk("grant_onehot", int'(grant), int'(exp_grant));
        end
`ifndef RR_ARB_TIMEOUT_EN
        if (timeout !== 1'b0) begin
            chk("timeout_tied_low", int'(timeout), 0);
        end
`endif
        if (grant_valid === 1'b1 && (prev_valid !== 1'b1 || grant_idx !== prev_idx)) begin
            chk("idle_gap_before_grant", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                chk("unexpected_grant_idx", int'(grant_idx), -1);
            end else begin
                e = sb.pop_front();
                $display("grant: cycle %0d idx %0d (expected idx %0d at cycle %0d)",
                         cyc, grant_idx, e.idx, e.at);
                chk("grant_idx", int'(grant_idx), e.idx);
                chk("grant_cycle", cyc, e.at);
            end
        end
        prev_valid = grant_valid;
        prev_idx   = grant_idx;
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("reset_valid", int'(grant_valid), 0);
        chk("reset_idx", int'(grant_idx), 0);
        chk("reset_grant", int'(grant), 0);
        chk("reset_timeout", int'(timeout), 0);
        rst = 1'b0;

        // No requests: nothing granted.
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b0);
            chk("idle_valid", int'(grant_valid), 0);
            chk("idle_grant", int'(grant), 0);
        end

        // req=0x24 from ptr=0: 2, then 5, then wrap to 2.
        expect_at(2, 1);
        step(8'h24, 1'b0);
        expect_at(5, 2);
        step(8'h24, 1'b1);
        step(8'h24, 1'b0);
        expect_at(2, 2);
        step(8'h24, 1'b1);
        step(8'h24, 1'b0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);

        // All requesting, done held high (ignored while idle): 0..7,0 with gaps.
        rst = 1'b1;
        step(8'h00, 1'b0);
        rst = 1'b0;
        expect_at(0, 1);
        step(8'hFF, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            expect_at(k % 8, 2);
            step(8'hFF, 1'b1);
            step(8'hFF, 1'b1);
        end
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);

        // ptr=1: owner 3 granted, others' changes ignored, then req[3] drops without done.
        expect_at(3, 1);
        step(8'h48, 1'b0);
        step(8'h0A, 1'b0);
        chk("hold_owner3_valid", int'(grant_valid), 1);
        chk("hold_owner3_idx", int'(grant_idx), 3);
        expect_at(6, 2);
        step(8'h42, 1'b0);
        chk("drop_release_valid", int'(grant_valid), 0);
        step(8'h42, 1'b0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);

        // ptr=7: wrap search to 6, then reset mid-grant, then ptr back at 0.
        expect_at(6, 1);
        step(8'h40, 1'b0);
        rst = 1'b1;
        step(8'h40, 1'b0);
        chk("midgrant_reset_valid", int'(grant_valid), 0);
        chk("midgrant_reset_idx", int'(grant_idx), 0);
        chk("midgrant_reset_grant", int'(grant), 0);
        rst = 1'b0;
        expect_at(0, 1);
        step(8'hC1, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // ptr=1, owner 1 never sends done.
        expect_at(1, 1);
        step(8'h06, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
        expect_at(2, 5);
        for (int i = 0; i < 3; i++) begin
            step(8'h06, 1'b0);
            chk("timeout_quiet", int'(timeout), 0);
        end
        step(8'h06, 1'b0);
        chk("timeout_pulse", int'(timeout), 1);
        chk("forced_release_valid", int'(grant_valid), 0);
        step(8'h06, 1'b0);
        chk("timeout_one_cycle", int'(timeout), 0);
`else
        for (int i = 0; i < 20; i++) begin
            step(8'h06, 1'b0);
        end
        chk("long_hold_valid", int'(grant_valid), 1);
        chk("long_hold_idx", int'(grant_idx), 1);
`endif
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
